ball_pocket_sequencer: RTL and testbench
========================================

# ball_pocket_sequencer

Per-ball lifecycle controller that sits between the ball motion logic and the ball drawing block. It decides where the ball is drawn and whether it is visible. During play it passes the motion position through. When the ball is pocketed it parks the ball on the pocket, blinks it, hides it for a fixed time, then respawns it at the spawn spot once that spot is clear. It also reloads the motion block's position and freezes motion while the ball is out of play.

## Interface
Parameters:
- SPAWN_X, 160, spawn top-left X (11-bit).
- SPAWN_Y, 224, spawn top-left Y (11-bit).
- BLINK_FRAMES, 8, frames per blink half-period, ≥1.
- BLINK_TOGGLES, 6, blink half-periods in SINK, ≥1.
- HIDDEN_FRAMES, 60, frames spent in HIDDEN, ≥1, ≤255.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, synchronous, active-low.
- startOfFrame  in  1  one-cycle pulse per video frame.
- pocketHit  in  1  one-cycle pulse: ball entered a pocket.
- pocketTopLeftX / pocketTopLeftY  in  11 each  top-left of the pocketed position, valid with pocketHit.
- motionTopLeftX / motionTopLeftY  in  11 each  ball position from the motion block.
- spawnClear  in  1  level: no other ball overlaps the spawn spot.
- ballTopLeftPosX / ballTopLeftPosY  out  11 each  position to the drawing block.
- ballVisible  out  1  gates the ball's drawing request.
- ballFrozen  out  1  motion block holds position and zeroes speed.
- loadPos  out  1  one-cycle pulse: motion block loads loadPosX/Y.
- loadPosX / loadPosY  out  11 each  constant SPAWN_X / SPAWN_Y.
- pocketedCount  out  4  number of completed pockets, saturates at 15.

## Operation
States: RESPAWN, PLAY, SINK, HIDDEN.

Internal counters:
- frameCnt, 8-bit.
- toggleCnt, sized for BLINK_TOGGLES.

**PLAY**
- ballTopLeftPos follows motionTopLeft; ballVisible=1; ballFrozen=0.
- pocketHit on any cycle → SINK. Latch pocketTopLeft; clear frameCnt and toggleCnt.

**SINK**
- ballTopLeftPos = latched pocket; ballFrozen=1; ballVisible = ~toggleCnt[0] (starts visible).
- On each startOfFrame, frameCnt increments.
- At frameCnt==BLINK_FRAMES-1: frameCnt clears and toggleCnt increments.
- If toggleCnt==BLINK_TOGGLES-1 at that point → HIDDEN. frameCnt clears and pocketedCount increments (saturating).
- pocketHit is ignored.

**HIDDEN**
- ballVisible=0; ballFrozen=1; position held.
- On the HIDDEN_FRAMES-th startOfFrame → RESPAWN.

**RESPAWN**
- ballVisible=0; ballFrozen=1.
- On a startOfFrame cycle with spawnClear=1 → PLAY. Pulse loadPos for one cycle; ballTopLeftPos = SPAWN_X/Y.
- With spawnClear=0 it stays in RESPAWN indefinitely and re-checks every frame.

**Simultaneous events**
- pocketHit together with startOfFrame in PLAY: enter SINK; that frame is not counted.
- pocketHit in SINK, HIDDEN or RESPAWN: ignored.

**Reset (resetN=0 at clk edge, at any time, mid-sequence included)**
- state=RESPAWN; ballTopLeftPos=SPAWN_X/SPAWN_Y; ballVisible=0; ballFrozen=1; loadPos=0.
- Counters=0; pocketedCount=0.

**Arithmetic**
- Unsigned 11-bit positions, no arithmetic on them.
- Counters compare with ==; no wrap is reachable within legal parameters.

## Timing
- All outputs are registered; input-to-output latency is 1 clk.
- PLAY position is motionTopLeft delayed by 1 clk.
- pocketHit at edge N: at N+1 ballTopLeftPos = pocket coordinates, ballFrozen=1, ballVisible=1.
- SINK lasts exactly BLINK_FRAMES×BLINK_TOGGLES startOfFrame pulses; with defaults, 48 frames (8 visible, 8 hidden, ×3).
- HIDDEN lasts exactly HIDDEN_FRAMES pulses.
- loadPos is high for exactly one clk, coincident with the first PLAY cycle's outputs. In that cycle ballFrozen=0 and ballVisible=1.
- Next cycle, ballTopLeftPos tracks motionTopLeft.
- After reset, the first startOfFrame with spawnClear=1 produces loadPos.

## Test plan
- Reset, spawnClear=1, pulse startOfFrame → one cycle later: loadPos=1, pos=(160,224), ballVisible=1, ballFrozen=0; following cycle, pos tracks motion (e.g. 300,200).
- In PLAY, pocketHit with pocket (20,20) → next cycle: pos=(20,20), ballFrozen=1; ballVisible pattern 1/0/1/0/1/0 in 8-frame blocks; HIDDEN after frame 48; pocketedCount=1.
- In HIDDEN, count 60 frames → RESPAWN; hold spawnClear=0 for 5 frames → no loadPos; raise it → loadPos on the next startOfFrame.
- pocketHit coincident with startOfFrame, plus extra pocketHit pulses during SINK → frame count starts on the next pulse; the extra hits are ignored and pocketedCount increments only once.
- Assert resetN=0 mid-SINK (frame 20) → next cycle: RESPAWN values, pocketedCount=0, ballVisible=0.
- Run 16 full pocket cycles → pocketedCount saturates at 15.

Source files
------------

// File: rtl/ball_pocket_sequencer.sv
// ball_pocket_sequencer: per-ball lifecycle (play, sink blink, hidden, respawn)
// between the motion logic and the drawing block; all outputs registered.
module ball_pocket_sequencer #(
   parameter logic [10:0] SPAWN_X       = 11'd160,
   parameter logic [10:0] SPAWN_Y       = 11'd224,
   parameter int unsigned BLINK_FRAMES  = 8,
   parameter int unsigned BLINK_TOGGLES = 6,
   parameter int unsigned HIDDEN_FRAMES = 60
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        pocketHit,
   input  logic [10:0] pocketTopLeftX,
   input  logic [10:0] pocketTopLeftY,
   input  logic [10:0] motionTopLeftX,
   input  logic [10:0] motionTopLeftY,
   input  logic        spawnClear,
   output logic [10:0] ballTopLeftPosX,
   output logic [10:0] ballTopLeftPosY,
   output logic        ballVisible,
   output logic        ballFrozen,
   output logic        loadPos,
   output logic [10:0] loadPosX,
   output logic [10:0] loadPosY,
   output logic [3:0]  pocketedCount
);
   localparam int TW = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;
   localparam logic [TW-1:0] TOG_LAST   = TW'(BLINK_TOGGLES - 1);
   localparam logic [7:0]    BLINK_LAST = 8'(BLINK_FRAMES - 1);
   localparam logic [7:0]    HID_LAST   = 8'(HIDDEN_FRAMES - 1);

   typedef enum logic [1:0] {RESPAWN, PLAY, SINK, HIDDEN} state_t;

   state_t        state_q, state_d;
   logic [7:0]    frame_q, frame_d;
   logic [TW-1:0] tog_q, tog_d;
   logic [10:0]   pk_x_q, pk_x_d, pk_y_q, pk_y_d;
   logic [10:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic          vis_q, vis_d, frz_q, frz_d, load_q, load_d;
   logic [3:0]    cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      tog_d   = tog_q;
      pk_x_d  = pk_x_q;
      pk_y_d  = pk_y_q;
      cnt_d   = cnt_q;
      load_d  = 1'b0;
      case (state_q)
         PLAY: if (pocketHit) begin
            state_d = SINK;
            pk_x_d  = pocketTopLeftX;
            pk_y_d  = pocketTopLeftY;
            frame_d = '0;
            tog_d   = '0;
         end
         SINK: if (startOfFrame) begin
            frame_d = (frame_q == BLINK_LAST) ? 8'd0 : frame_q + 8'd1;
            if (frame_q == BLINK_LAST) begin
               tog_d = tog_q + 1'b1;
               if (tog_q == TOG_LAST) begin
                  state_d = HIDDEN;
                  cnt_d   = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
               end
            end
         end
         HIDDEN: if (startOfFrame) begin
            frame_d = (frame_q == HID_LAST) ? 8'd0 : frame_q + 8'd1;
            if (frame_q == HID_LAST) state_d = RESPAWN;
         end
         RESPAWN: if (startOfFrame && spawnClear) begin
            state_d = PLAY;
            load_d  = 1'b1;
         end
         default: state_d = RESPAWN;
      endcase
      // outputs are computed from the next state so they land with the transition
      vis_d   = (state_d == PLAY) || (state_d == SINK && !tog_d[0]);
      frz_d   = (state_d != PLAY);
      pos_x_d = (state_d == PLAY) ? (load_d ? SPAWN_X : motionTopLeftX) :
                (state_d == SINK) ? pk_x_d : pos_x_q;
      pos_y_d = (state_d == PLAY) ? (load_d ? SPAWN_Y : motionTopLeftY) :
                (state_d == SINK) ? pk_y_d : pos_y_q;
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q <= RESPAWN;
         frame_q <= '0;
         tog_q   <= '0;
         pk_x_q  <= '0;
         pk_y_q  <= '0;
         cnt_q   <= '0;
         pos_x_q <= SPAWN_X;
         pos_y_q <= SPAWN_Y;
         vis_q   <= 1'b0;
         frz_q   <= 1'b1;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         frame_q <= frame_d;
         tog_q   <= tog_d;
         pk_x_q  <= pk_x_d;
         pk_y_q  <= pk_y_d;
         cnt_q   <= cnt_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
         vis_q   <= vis_d;
         frz_q   <= frz_d;
         load_q  <= load_d;
      end
   end

   assign ballTopLeftPosX = pos_x_q;
   assign ballTopLeftPosY = pos_y_q;
   assign ballVisible     = vis_q;
   assign ballFrozen      = frz_q;
   assign loadPos         = load_q;
   assign loadPosX        = SPAWN_X;
   assign loadPosY        = SPAWN_Y;
   assign pocketedCount   = cnt_q;
endmodule

// File: tb/tb_ball_pocket_sequencer.sv
// tb_ball_pocket_sequencer: directed stimulus, lifecycle model checked every
// cycle on the falling edge, plus literal expectations at key points.
module tb_ball_pocket_sequencer;
   localparam int BF = 8, BT = 6, HF = 60;
   localparam int M_RESP = 0, M_PLAY = 1, M_SINK = 2, M_HID = 3;

   logic        clk = 1'b0;
   logic        resetN, sof, hit, clear;
   logic [10:0] pkx, pky, mx, my;
   logic [10:0] ox, oy, lx, ly;
   logic        vis, frz, load;
   logic [3:0]  cnt;

   int total = 0, bad = 0;
   logic chk_en = 1'b0;

   ball_pocket_sequencer dut (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .pocketHit(hit),
      .pocketTopLeftX(pkx), .pocketTopLeftY(pky),
      .motionTopLeftX(mx), .motionTopLeftY(my), .spawnClear(clear),
      .ballTopLeftPosX(ox), .ballTopLeftPosY(oy), .ballVisible(vis),
      .ballFrozen(frz), .loadPos(load), .loadPosX(lx), .loadPosY(ly),
      .pocketedCount(cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: mode plus frames elapsed in the current mode
   int m_mode = M_RESP, m_fr = 0, m_cnt = 0;
   int e_x = 160, e_y = 224, m_px = 0, m_py = 0;
   bit e_vis = 0, e_frz = 1, e_load = 0;

   always @(posedge clk) begin
      if (!resetN) begin
         m_mode = M_RESP; m_fr = 0; m_cnt = 0; e_x = 160; e_y = 224; e_load = 0;
      end else begin
         e_load = 0;
         case (m_mode)
            M_PLAY: if (hit) begin
               m_mode = M_SINK; m_fr = 0; m_px = pkx; m_py = pky; e_x = pkx; e_y = pky;
            end else begin
               e_x = mx; e_y = my;
            end
            M_SINK: if (sof) begin
               m_fr++;
               if (m_fr == BF * BT) begin
                  m_mode = M_HID; m_fr = 0; m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
               end
            end
            M_HID: if (sof) begin
               m_fr++;
               if (m_fr == HF) begin m_mode = M_RESP; m_fr = 0; end
            end
            default: if (sof && clear) begin
               m_mode = M_PLAY; e_load = 1; e_x = 160; e_y = 224;
            end
         endcase
      end
      e_vis = (m_mode == M_PLAY) || (m_mode == M_SINK && ((m_fr / BF) % 2 == 0));
      e_frz = (m_mode != M_PLAY);
   end

   always @(negedge clk) if (chk_en) begin
      chk("pos_x", ox, e_x);
      chk("pos_y", oy, e_y);
      chk("visible", vis, e_vis);
      chk("frozen", frz, e_frz);
      chk("loadPos", load, e_load);
      chk("pocketedCount", cnt, m_cnt);
      chk("loadPosXY", {lx, ly}, {11'd160, 11'd224});
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic sof_pulse();
      sof = 1'b1; tick(); sof = 1'b0;
   endtask

   task automatic frames(input int n);
      repeat (n) begin sof_pulse(); tick(); tick(); end
   endtask

   task automatic pocket_cycle(input bit literal);
      hit = 1'b1; pkx = 11'd20; pky = 11'd20; tick(); hit = 1'b0;
      if (literal) begin
         chk("hit_pos_x", ox, 20); chk("hit_pos_y", oy, 20);
         chk("hit_frozen", frz, 1); chk("hit_visible", vis, 1);
      end
      for (int f = 1; f <= BF * BT; f++) begin
         sof_pulse();
         if (literal && f == 7)  chk("blink_f7", vis, 1);
         if (literal && f == 8)  chk("blink_f8", vis, 0);
         if (literal && f == 16) chk("blink_f16", vis, 1);
         if (literal && f == 47) chk("blink_f47", vis, 0);
         tick(); tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      resetN = 1'b0; sof = 1'b0; hit = 1'b0; clear = 1'b1;
      pkx = '0; pky = '0; mx = 11'd300; my = 11'd200;
      tick(); chk_en = 1'b1; tick();
      chk("rst_load", load, 0); chk("rst_vis", vis, 0); chk("rst_frz", frz, 1);
      chk("rst_x", ox, 160); chk("rst_y", oy, 224); chk("rst_cnt", cnt, 0);
      resetN = 1'b1; tick(); tick();
      sof_pulse();
      chk("first_load", load, 1); chk("first_x", ox, 160); chk("first_y", oy, 224);
      chk("first_vis", vis, 1); chk("first_frz", frz, 0);
      tick();
      chk("track_load", load, 0); chk("track_x", ox, 300); chk("track_y", oy, 200);
      for (int i = 0; i < 4; i++) begin mx = 11'(100 + 7 * i); my = 11'(50 + 3 * i); tick(); end
      sof_pulse(); tick();
      pocket_cycle(1'b1);
      chk("sink_done_cnt", cnt, 1); chk("sink_done_vis", vis, 0);
      frames(HF - 1);
      chk("hidden59_frz", frz, 1);
      sof_pulse();
      chk("hidden60_noload", load, 0);
      clear = 1'b0; tick();
      frames(5);
      chk("blocked_noload", load, 0);
      clear = 1'b1; sof_pulse();
      chk("respawn_load", load, 1);
      tick(); mx = 11'd500; my = 11'd400; tick(); tick();
      // pocket with a coincident frame pulse, then stray hits during the sink
      hit = 1'b1; sof = 1'b1; pkx = 11'd700; pky = 11'd33; tick(); hit = 1'b0; sof = 1'b0;
      chk("coinc_x", ox, 700); chk("coinc_vis", vis, 1);
      for (int f = 1; f <= BF * BT; f++) begin
         hit = (f == 3); pkx = 11'd1; pky = 11'd2;
         sof = (f == 10) ? 1'b0 : 1'b1;
         if (f == 10) begin hit = 1'b1; tick(); hit = 1'b0; sof = 1'b1; end
         tick(); sof = 1'b0; hit = 1'b0; tick();
         if (f == 8) chk("coinc_f8_vis", vis, 0);
      end
      chk("coinc_cnt", cnt, 2);
      hit = 1'b1; tick(); hit = 1'b0;
      frames(HF);
      chk("hidden_hit_cnt", cnt, 2);
      sof_pulse(); tick();
      hit = 1'b1; pkx = 11'd20; pky = 11'd20; tick(); hit = 1'b0;
      frames(20);
      resetN = 1'b0; tick(); resetN = 1'b1;
      chk("midrst_cnt", cnt, 0); chk("midrst_vis", vis, 0);
      chk("midrst_x", ox, 160); chk("midrst_frz", frz, 1);
      tick();
      for (int c = 0; c < 16; c++) begin
         sof_pulse(); tick();
         pocket_cycle(1'b0);
         frames(HF);
      end
      chk("sat_cnt", cnt, 15);
      tick(); tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
